// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types for the dcache write buffer: entry layout, FSM encoding and
// the default buffer depth.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef struct packed {
    word_t addr;
    word_t data;
  } wb_entry_t;

  localparam int WB_DEPTH_DEFAULT = 4;

  typedef enum logic {
    WB_IDLE  = 1'b0,
    WB_WRITE = 1'b1
  } wb_state_t;

  // Stored addresses are always word aligned.
  function automatic word_t word_align(input word_t a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/wbuf_match.sv
// Youngest-match lookup over the write-buffer entries. Age order is recovered from the
// tail pointer: the entry just behind tail is the youngest.
module wbuf_match
  import cpu_types_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH_DEFAULT,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] valid,
  input  wb_entry_t        entries [DEPTH],
  input  logic [PW-1:0]    tail,
  input  word_t            addr,
  output logic             hit,
  output logic [PW-1:0]    idx
);

  logic [DEPTH-1:0] eq;
  logic [DEPTH-1:0] unused_fields;
  logic             unused_addr_lsb;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
    assign eq[gi]            = valid[gi] && (entries[gi].addr[31:2] == addr[31:2]);
    assign unused_fields[gi] = ^{entries[gi].data, entries[gi].addr[1:0]};
  end

  assign unused_addr_lsb = ^addr[1:0];

  // Scan from oldest to youngest so the last hit written is the youngest one.
  always_comb begin
    logic [PW-1:0] pos;
    pos = '0;
    hit = 1'b0;
    idx = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      pos = tail - PW'(k + 1);
      if (eq[pos]) begin
        hit = 1'b1;
        idx = pos;
      end
    end
  end

endmodule

// File: rtl/dcache_write_buffer.sv
// Posted-write FIFO between the dcache writeback path and the memory controller, with
// youngest-entry forwarding to refill reads. Define WB_COALESCE_EN to merge same-address words.
module dcache_write_buffer
  import cpu_types_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH_DEFAULT,
  parameter int CPUID = 0
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  wb_req,
  input  word_t wb_addr,
  input  word_t wb_data,
  output logic  wb_ready,
  input  word_t ld_addr,
  output logic  ld_hit,
  output word_t ld_data,
  input  logic  hold,
  output logic  dWEN,
  output word_t daddr,
  output word_t dstore,
  input  logic  dwait,
  output logic  empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);
  localparam logic [0:0]  S_IDLE     = WB_IDLE;
  localparam logic [0:0]  S_WRITE    = WB_WRITE;

  // DEPTH must be a power of two of at least 2; CPUID only names the controller slot.
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (CPUID < 0)) begin : g_bad_params
  end

  logic [0:0]    state_q, state_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW:0]   count_q, count_d;
  wb_entry_t     entries_q [DEPTH];
  wb_entry_t     entries_d [DEPTH];

  logic [DEPTH-1:0] valid;
  logic             ld_match;
  logic [PW-1:0]    ld_idx;
  logic             coal_hit;
  logic [PW-1:0]    coal_idx;
  logic             accept;
  logic             alloc;
  logic             merge;
  logic             retire;
  wb_entry_t        head_entry;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
    logic [PW-1:0] rel;
    assign rel       = PW'(gi) - head_q;
    assign valid[gi] = {1'b0, rel} < count_q;
  end

  wbuf_match #(.DEPTH(DEPTH)) u_ld_match (
    .valid   (valid),
    .entries (entries_q),
    .tail    (tail_q),
    .addr    (ld_addr),
    .hit     (ld_match),
    .idx     (ld_idx)
  );

`ifdef WB_COALESCE_EN
  // The head being written out must not change under the controller, so it is excluded.
  logic [DEPTH-1:0] coal_valid;
  assign coal_valid = valid & ~((state_q == S_WRITE) ? (DEPTH'(1) << head_q) : '0);

  wbuf_match #(.DEPTH(DEPTH)) u_coal_match (
    .valid   (coal_valid),
    .entries (entries_q),
    .tail    (tail_q),
    .addr    (wb_addr),
    .hit     (coal_hit),
    .idx     (coal_idx)
  );
`else
  assign coal_hit = 1'b0;
  assign coal_idx = '0;
`endif

  assign wb_ready = (count_q != FULL_COUNT) || coal_hit;
  assign accept   = wb_req && wb_ready;
  assign alloc    = accept && !coal_hit;
  assign merge    = accept && coal_hit;
  assign retire   = (state_q == S_WRITE) && !dwait;

  always_comb begin
    head_d  = retire ? head_q + PW'(1) : head_q;
    tail_d  = alloc ? tail_q + PW'(1) : tail_q;
    count_d = count_q;
    if (alloc && !retire) begin
      count_d = count_q + (PW + 1)'(1);
    end else if (!alloc && retire) begin
      count_d = count_q - (PW + 1)'(1);
    end
  end

  always_comb begin
    entries_d = entries_q;
    if (alloc) begin
      entries_d[tail_q].addr = word_align(wb_addr);
      entries_d[tail_q].data = wb_data;
    end
    if (merge) begin
      entries_d[coal_idx].data = wb_data;
    end
  end

  // Once a write is presented it is held until the controller takes it; hold only gates starts.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if ((count_q != '0) && !hold) begin
          state_d = S_WRITE;
        end
      end
      default: begin
        if (!dwait && ((count_d == '0) || hold)) begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= S_IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      entries_q <= entries_d;
    end
  end

  assign head_entry = entries_q[head_q];
  assign dWEN       = (state_q == S_WRITE);
  assign daddr      = dWEN ? head_entry.addr : '0;
  assign dstore     = dWEN ? head_entry.data : '0;
  assign empty      = (count_q == '0) && !dWEN;

  assign ld_hit  = ld_match;
  assign ld_data = ld_match ? entries_q[ld_idx].data : '0;

endmodule

// File: tb/tb_dcache_write_buffer.sv
// Directed bench for dcache_write_buffer: a queue scoreboard models the expected
// memory-controller write stream; forwarding and handshake flags are checked inline.
module tb_dcache_write_buffer;
  import cpu_types_pkg::*;

  localparam word_t IDLE_ADDR = 32'hFFFF_FFF0;

  logic  CLK = 1'b0;
  logic  nRST;
  logic  wb_req;
  word_t wb_addr;
  word_t wb_data;
  logic  wb_ready;
  word_t ld_addr;
  logic  ld_hit;
  word_t ld_data;
  logic  hold;
  logic  dWEN;
  word_t daddr;
  word_t dstore;
  logic  dwait;
  logic  empty;

  int checks = 0;
  int errors = 0;
  wb_entry_t sb[$];

  dcache_write_buffer #(.DEPTH(4), .CPUID(0)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .wb_req   (wb_req),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .wb_ready (wb_ready),
    .ld_addr  (ld_addr),
    .ld_hit   (ld_hit),
    .ld_data  (ld_data),
    .hold     (hold),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .dwait    (dwait),
    .empty    (empty)
  );

  always #5 CLK = ~CLK;

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input word_t obs, input word_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the edge that sampled the request.
  task automatic enq(input word_t a, input word_t d, input logic exp_rdy);
    wb_entry_t e;
    wb_req  = 1'b1;
    wb_addr = a;
    wb_data = d;
    @(negedge CLK);
    chk1($sformatf("wb_ready@%h", a), wb_ready, exp_rdy);
    if (exp_rdy) begin
      e.addr = word_align(a);
      e.data = d;
      sb.push_back(e);
    end
    $display("enq    addr=%h data=%h accepted=%b", a, d, exp_rdy);
    cyc();
    wb_req  = 1'b0;
    wb_addr = IDLE_ADDR;
  endtask

`ifdef WB_COALESCE_EN
  task automatic enq_merge(input word_t a, input word_t d, input int idx);
    wb_entry_t e;
    wb_req  = 1'b1;
    wb_addr = a;
    wb_data = d;
    @(negedge CLK);
    chk1($sformatf("wb_ready_merge@%h", a), wb_ready, 1'b1);
    e = sb[idx];
    e.data = d;
    sb[idx] = e;
    $display("merge  addr=%h data=%h", a, d);
    cyc();
    wb_req  = 1'b0;
    wb_addr = IDLE_ADDR;
  endtask
`endif

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while (!(empty === 1'b1 && sb.size() == 0) && n < budget) begin
      cyc();
      n++;
    end
    checks++;
    assert ((n < budget) === 1'b1) else begin
      errors++;
      $error("FAIL %s: observed empty=%b pending=%0d expected empty=1 pending=0",
             tag, empty, sb.size());
    end
  endtask

  // Memory-controller side: every completed write must be the oldest expected word.
  always @(negedge CLK) begin
    if (nRST === 1'b1 && dWEN === 1'b1 && dwait === 1'b0) begin
      wb_entry_t e;
      $display("write  addr=%h data=%h", daddr, dstore);
      checks++;
      assert ((sb.size() != 0) === 1'b1) else begin
        errors++;
        $error("FAIL unexpected_write: observed addr=%h data=%h expected none", daddr, dstore);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk32("drain_addr", daddr, e.addr);
        chk32("drain_data", dstore, e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    nRST    = 1'b0;
    wb_req  = 1'b0;
    wb_addr = IDLE_ADDR;
    wb_data = '0;
    ld_addr = '0;
    hold    = 1'b0;
    dwait   = 1'b0;

    // Power-on reset
    cyc();
    cyc();
    nRST = 1'b1;
    @(negedge CLK);
    chk1("rst_dWEN", dWEN, 1'b0);
    chk1("rst_empty", empty, 1'b1);
    chk1("rst_wb_ready", wb_ready, 1'b1);
    chk1("rst_ld_hit", ld_hit, 1'b0);
    chk32("rst_daddr", daddr, 32'h0);
    chk32("rst_dstore", dstore, 32'h0);
    cyc();

    // Single write held off by dwait for 10 cycles
    dwait = 1'b1;
    enq(32'h40, 32'hDEADBEEF, 1'b1);
    @(negedge CLK);
    chk1("single_dWEN_first", dWEN, 1'b0);
    chk1("single_not_empty", empty, 1'b0);
    ld_addr = 32'h40;
    #1;
    chk1("single_ld_hit", ld_hit, 1'b1);
    chk32("single_ld_data", ld_data, 32'hDEADBEEF);
    cyc();
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      chk1("single_dWEN", dWEN, 1'b1);
      chk32("single_daddr", daddr, 32'h40);
      chk32("single_dstore", dstore, 32'hDEADBEEF);
      cyc();
    end
    dwait = 1'b0;
    @(negedge CLK);
    cyc();
    @(negedge CLK);
    chk1("single_empty_after", empty, 1'b1);
    chk1("single_dWEN_after", dWEN, 1'b0);
    cyc();

    // Fill under hold (last address unaligned), overflow attempt, drain, then more across wrap
    hold = 1'b1;
    enq(32'h00, 32'hA0, 1'b1);
    enq(32'h04, 32'hA1, 1'b1);
    enq(32'h08, 32'hA2, 1'b1);
    enq(32'h0F, 32'hA3, 1'b1);
    @(negedge CLK);
    chk1("full_wb_ready", wb_ready, 1'b0);
    chk1("full_hold_dWEN", dWEN, 1'b0);
    cyc();
    enq(32'h1C, 32'hA4, 1'b0);
    hold = 1'b0;
    wait_drain("fill_drain", 40);
    enq(32'h10, 32'hB0, 1'b1);
    enq(32'h14, 32'hB1, 1'b1);
    wait_drain("wrap_drain", 40);

    // Forwarding: same-cycle invisibility, youngest wins, lsbs ignored, miss returns 0
    hold    = 1'b1;
    ld_addr = 32'h80;
    wb_req  = 1'b1;
    wb_addr = 32'h80;
    wb_data = 32'h1111;
    @(negedge CLK);
    chk1("fwd_wb_ready", wb_ready, 1'b1);
    chk1("fwd_not_yet_visible", ld_hit, 1'b0);
    begin
      wb_entry_t e;
      e.addr = 32'h80;
      e.data = 32'h1111;
      sb.push_back(e);
    end
    cyc();
    wb_req  = 1'b0;
    wb_addr = IDLE_ADDR;
    @(negedge CLK);
    chk1("fwd_hit_old", ld_hit, 1'b1);
    chk32("fwd_data_old", ld_data, 32'h1111);
    cyc();
`ifdef WB_COALESCE_EN
    enq_merge(32'h80, 32'h2222, 0);
`else
    enq(32'h80, 32'h2222, 1'b1);
`endif
    @(negedge CLK);
    chk1("fwd_hit_young", ld_hit, 1'b1);
    chk32("fwd_data_young", ld_data, 32'h2222);
    ld_addr = 32'h84;
    #1;
    chk1("fwd_miss_hit", ld_hit, 1'b0);
    chk32("fwd_miss_data", ld_data, 32'h0);
    ld_addr = 32'h83;
    #1;
    chk1("fwd_lsb_hit", ld_hit, 1'b1);
    chk32("fwd_lsb_data", ld_data, 32'h2222);
    cyc();
    hold = 1'b0;
    wait_drain("fwd_drain", 40);

    // Simultaneous enqueue and retire at count=2
    hold  = 1'b1;
    dwait = 1'b1;
    enq(32'h100, 32'h1, 1'b1);
    enq(32'h104, 32'h2, 1'b1);
    hold = 1'b0;
    cyc();
    @(negedge CLK);
    chk1("sim_dWEN", dWEN, 1'b1);
    chk32("sim_daddr_A", daddr, 32'h100);
    cyc();
    dwait   = 1'b0;
    wb_req  = 1'b1;
    wb_addr = 32'h108;
    wb_data = 32'h3;
    ld_addr = 32'h100;
    @(negedge CLK);
    chk1("sim_wb_ready", wb_ready, 1'b1);
    chk1("sim_retiring_hit", ld_hit, 1'b1);
    chk32("sim_retiring_data", ld_data, 32'h1);
    begin
      wb_entry_t e;
      e.addr = 32'h108;
      e.data = 32'h3;
      sb.push_back(e);
    end
    cyc();
    wb_req  = 1'b0;
    wb_addr = IDLE_ADDR;
    dwait   = 1'b1;
    @(negedge CLK);
    chk1("sim_dWEN_next", dWEN, 1'b1);
    chk32("sim_daddr_B", daddr, 32'h104);
    chk1("sim_retired_gone", ld_hit, 1'b0);
    cyc();
    enq(32'h10C, 32'h4, 1'b1);
    enq(32'h110, 32'h5, 1'b1);
    @(negedge CLK);
    chk1("sim_count_full", wb_ready, 1'b0);
    cyc();
    dwait = 1'b0;
    wait_drain("sim_drain", 40);

    // Full buffer, enqueue matching a resident non-head entry
    hold = 1'b1;
    enq(32'h00, 32'h10, 1'b1);
    enq(32'h04, 32'h11, 1'b1);
    enq(32'h08, 32'h12, 1'b1);
    enq(32'h0C, 32'h13, 1'b1);
`ifdef WB_COALESCE_EN
    enq_merge(32'h08, 32'hAAAA, 2);
`else
    enq(32'h08, 32'hAAAA, 1'b0);
`endif
    @(negedge CLK);
    chk1("coal_still_full", wb_ready, 1'b0);
    cyc();
    hold = 1'b0;
    wait_drain("coal_drain", 40);

    // Reset in the middle of a stalled write: the write is dropped
    dwait = 1'b1;
    enq(32'h200, 32'h77, 1'b1);
    cyc();
    @(negedge CLK);
    chk1("rst2_dWEN_before", dWEN, 1'b1);
    chk32("rst2_daddr_before", daddr, 32'h200);
    cyc();
    nRST = 1'b0;
    cyc();
    cyc();
    nRST = 1'b1;
    sb.delete();
    ld_addr = 32'h200;
    @(negedge CLK);
    chk1("rst2_dWEN", dWEN, 1'b0);
    chk1("rst2_empty", empty, 1'b1);
    chk1("rst2_wb_ready", wb_ready, 1'b1);
    chk1("rst2_ld_hit", ld_hit, 1'b0);
    cyc();
    dwait = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk1("rst2_no_replay", dWEN, 1'b0);
      cyc();
    end
    enq(32'h300, 32'h99, 1'b1);
    wait_drain("rst2_drain", 40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
